// File: rtl/hd_arith_pkg.sv
// Shared arithmetic constants and helpers for the HD accelerator datapath.
// Provides vector/input widths and signed saturation limits per width.
package hd_arith_pkg;

  localparam int DIM_WIDTH   = 16;
  localparam int INPUT_WIDTH = 8;

  // Largest signed value of a w-bit word, zero-extended to 64 bits.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Smallest signed value of a w-bit word; the low w bits hold the pattern.
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, the link of the ripple-carry chain.
// Ports: a_i, b_i, cin_i -> s_o (sum), cout_o (carry out).
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/n_bit_adder.sv
// N-bit two's-complement ripple-carry adder: combinational sum/cout/ovf
// plus a one-cycle registered copy with valid. Macro N_BIT_ADDER_SAT_EN
// enables signed saturation of out/out_q. Ports: clk, reset (sync, high),
// input1, input2, in_valid -> out, cout, ovf, out_q, cout_q, ovf_q, out_valid.
module n_bit_adder
  import hd_arith_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  input  logic         in_valid,
  output logic [N-1:0] out,
  output logic         cout,
  output logic         ovf,
  output logic [N-1:0] out_q,
  output logic         cout_q,
  output logic         ovf_q,
  output logic         out_valid
);

  logic [N:0]   carry;
  logic [N-1:0] sum_raw;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a_i    (input1[i]),
      .b_i    (input2[i]),
      .cin_i  (carry[i]),
      .s_o    (sum_raw[i]),
      .cout_o (carry[i+1])
    );
  end

  assign cout = carry[N];

  // Overflow only when both operands share a sign the result lost.
  assign ovf = (input1[N-1] == input2[N-1]) &&
               (sum_raw[N-1] != input1[N-1]);

`ifdef N_BIT_ADDER_SAT_EN
  localparam logic [63:0] SAT_HI = sat_max(N);
  localparam logic [63:0] SAT_LO = sat_min(N);

  // On overflow the operand sign tells the direction.
  always_comb begin
    out = sum_raw;
    if (ovf) begin
      out = input1[N-1] ? SAT_LO[N-1:0] : SAT_HI[N-1:0];
    end
  end
`else
  assign out = sum_raw;
`endif

  logic [N-1:0] out_d;
  logic         cout_d;
  logic         ovf_d;
  logic         valid_d;

  always_comb begin
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = in_valid;
    if (in_valid) begin
      out_d  = out;
      cout_d = cout;
      ovf_d  = ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_q     <= out_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      out_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_n_bit_adder.sv
// Self-checking bench for n_bit_adder (N=16): vector table, corner
// sequences, and randomized stimulus against an arithmetic model.
module tb_n_bit_adder;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] input1, input2;
  logic         in_valid;
  logic [N-1:0] out, out_q;
  logic         cout, ovf, cout_q, ovf_q, out_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  n_bit_adder #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .input1    (input1),
    .input2    (input2),
    .in_valid  (in_valid),
    .out       (out),
    .cout      (cout),
    .ovf       (ovf),
    .out_q     (out_q),
    .cout_q    (cout_q),
    .ovf_q     (ovf_q),
    .out_valid (out_valid)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sum;
    logic         c;
    logic         v;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operands.
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] o, output logic c,
                       output logic v);
    int sa, sb, s;
    longint ua, ub;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = sa + sb;
    ua = longint'(a);
    ub = longint'(b);
    c  = (ua + ub) > 65535;
    v  = (s > 32767) || (s < -32768);
    o  = s[N-1:0];
`ifdef N_BIT_ADDER_SAT_EN
    if (v) o = (s > 0) ? 16'h7FFF : 16'h8000;
`endif
  endtask

  task automatic drive(input logic r, input logic iv,
                       input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    reset    = r;
    in_valid = iv;
    input1   = a;
    input2   = b;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] s, input logic c,
                         input logic v);
    vec_t t;
    t.a = a; t.b = b; t.sum = s; t.c = c; t.v = v;
    vecs.push_back(t);
  endtask

  logic [N-1:0] m_o, e_q;
  logic         m_c, m_v, e_c, e_v, e_val;

  initial begin
    add_vec(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
`ifdef N_BIT_ADDER_SAT_EN
    add_vec(16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    add_vec(16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b1);
`else
    add_vec(16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    add_vec(16'h8000, 16'hFFFF, 16'h7FFF, 1'b1, 1'b1);
`endif
    add_vec(16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0);
    add_vec(16'h0003, 16'hFFFE, 16'h0001, 1'b1, 1'b0);
    add_vec(16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0);

    reset = 1'b1; in_valid = 1'b0; input1 = '0; input2 = '0;
    after_edge();
    after_edge();
    chk("rst_out_q", 64'(out_q), 64'h0);
    chk("rst_cout_q", 64'(cout_q), 64'h0);
    chk("rst_ovf_q", 64'(ovf_q), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);

    foreach (vecs[i]) begin
      drive(1'b0, 1'b1, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_out", i), 64'(out), 64'(vecs[i].sum));
      chk($sformatf("v%0d_cout", i), 64'(cout), 64'(vecs[i].c));
      chk($sformatf("v%0d_ovf", i), 64'(ovf), 64'(vecs[i].v));
      after_edge();
      chk($sformatf("v%0d_out_q", i), 64'(out_q), 64'(vecs[i].sum));
      chk($sformatf("v%0d_cout_q", i), 64'(cout_q), 64'(vecs[i].c));
      chk($sformatf("v%0d_ovf_q", i), 64'(ovf_q), 64'(vecs[i].v));
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'h1);
    end

    // Reset wins over in_valid; comb path unaffected.
    drive(1'b1, 1'b1, 16'd5, 16'd6);
    chk("rst_comb_out", 64'(out), 64'h000B);
    after_edge();
    chk("rstdom_out_q", 64'(out_q), 64'h0);
    chk("rstdom_valid", 64'(out_valid), 64'h0);
    drive(1'b0, 1'b0, 16'd5, 16'd6);
    after_edge();
    chk("rel_out_q", 64'(out_q), 64'h0);
    chk("rel_valid", 64'(out_valid), 64'h0);

    // Back-to-back stream then idle.
    drive(1'b0, 1'b1, 16'd1, 16'd2);
    after_edge();
    chk("b2b0_out_q", 64'(out_q), 64'd3);
    chk("b2b0_valid", 64'(out_valid), 64'h1);
    drive(1'b0, 1'b1, 16'd3, 16'd4);
    after_edge();
    chk("b2b1_out_q", 64'(out_q), 64'd7);
    chk("b2b1_valid", 64'(out_valid), 64'h1);
    drive(1'b0, 1'b1, 16'd10, 16'd20);
    after_edge();
    chk("b2b2_out_q", 64'(out_q), 64'd30);
    chk("b2b2_valid", 64'(out_valid), 64'h1);
    drive(1'b0, 1'b0, 16'hAAAA, 16'h5555);
    after_edge();
    chk("idle_out_q", 64'(out_q), 64'd30);
    chk("idle_valid", 64'(out_valid), 64'h0);

    // Randomized run with a cycle-level expected register state.
    e_q = 16'd30; e_c = 1'b0; e_v = 1'b0; e_val = 1'b0;
    for (int k = 0; k < 300; k++) begin
      logic r, iv;
      logic [N-1:0] a, b;
      r  = ($urandom_range(0, 19) == 0);
      iv = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: a = 16'h7FFF;
        1: a = 16'h8000;
        default: a = N'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: b = 16'hFFFF;
        1: b = 16'h7FFF;
        default: b = N'($urandom);
      endcase
      drive(r, iv, a, b);
      model(a, b, m_o, m_c, m_v);
      chk("rnd_out", 64'(out), 64'(m_o));
      chk("rnd_cout", 64'(cout), 64'(m_c));
      chk("rnd_ovf", 64'(ovf), 64'(m_v));
      if (r) begin
        e_q = '0; e_c = 1'b0; e_v = 1'b0; e_val = 1'b0;
      end else begin
        e_val = iv;
        if (iv) begin
          e_q = m_o; e_c = m_c; e_v = m_v;
        end
      end
      after_edge();
      chk("rnd_out_q", 64'(out_q), 64'(e_q));
      chk("rnd_cout_q", 64'(cout_q), 64'(e_c));
      chk("rnd_ovf_q", 64'(ovf_q), 64'(e_v));
      chk("rnd_valid", 64'(out_valid), 64'(e_val));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/n_bit_adder.md
Name: n_bit_adder

Overview:
- Parameterised N-bit two's-complement adder; the leaf arithmetic cell of the HD accelerator's adder trees.
- Combinational sum path (zero latency) is used directly inside tree stages.
- A registered copy (one-cycle latency, with valid and status flags) serves pipelined tree stages and final accumulation.
- Built structurally as a ripple-carry chain of full-adder cells.

Parameters:
- N, 16, operand/result width in bits (legal range 2..64).

Ports:
- clk  input  1  rising-edge clock for the registered path.
- reset  input  1  synchronous, active-high; clears all registered outputs.
- input1  input  N  operand A, two's complement.
- input2  input  N  operand B, two's complement.
- in_valid  input  1  qualifies input1/input2 for capture into the registered path.
- out  output  N  combinational sum input1+input2, modulo 2^N.
- cout  output  1  combinational unsigned carry out of bit N-1.
- ovf  output  1  combinational signed overflow (operands same sign, result sign differs).
- out_q  output  N  registered sum.
- cout_q  output  1  registered cout.
- ovf_q  output  1  registered ovf.
- out_valid  output  1  registered in_valid.

Behaviour:
- out = (input1 + input2) mod 2^N; no internal sign extension (callers sign-extend narrower operands before connecting).
- Carry-in is fixed at 0.
- Combinational path: out/cout/ovf settle in the same cycle, independent of clk/reset.
- cout = carry out of MSB.
- ovf = (input1[N-1] == input2[N-1]) && (out[N-1] != input1[N-1]).
- Registered path, on each rising clk edge:
  - If reset: out_q=0, cout_q=0, ovf_q=0, out_valid=0.
  - Else if in_valid: out_q/cout_q/ovf_q <= out/cout/ovf; out_valid <= 1.
  - Else: out_q/cout_q/ovf_q hold; out_valid <= 0.
- Latency of the registered path is exactly 1 cycle; throughput is one sum per cycle.
- No backpressure.
- Reset dominates in_valid in the same cycle.
- Reset asserted mid-stream discards the in-flight value; the first valid result after reset deasserts appears 1 cycle after the first in_valid.
- Wrap-around is silent in the default build: ovf is flagged but the sum is not altered.
- Reset does not affect the combinational outputs.

Optional Feature:
- Macro: N_BIT_ADDER_SAT_EN.
- Defined:
  - out saturates on signed overflow: positive overflow gives 2^(N-1)-1; negative overflow gives -2^(N-1).
  - ovf still reports that overflow occurred.
  - out_q captures the saturated value.
  - cout is unchanged (raw carry).
- Undefined:
  - Pure modulo-2^N wrap.
  - No saturation logic is instantiated.

Decomposition:
- Shared package hd_arith_pkg:
  - Constant DIM_WIDTH=16.
  - Constant INPUT_WIDTH=8.
  - Function for the signed max/min saturation constants of a given width.
- One sub-module, full_adder (a, b, cin -> s, cout), replicated N times via generate.
- Overflow, saturation mux and output registers live in n_bit_adder.

Test Plan:
- N=16, input1=0xFFFF, input2=0x0001, in_valid=1 → out=0x0000, cout=1, ovf=0; next cycle out_q=0x0000, out_valid=1.
- input1=0x7FFF, input2=0x0001 → ovf=1; out=0x8000 by default, 0x7FFF with N_BIT_ADDER_SAT_EN.
- input1=0x8000, input2=0xFFFF → ovf=1, cout=1; out=0x7FFF by default, 0x8000 with N_BIT_ADDER_SAT_EN.
- Sign-extended bytes -1+-1 (0xFFFF+0xFFFF) → out=0xFFFE, ovf=0, cout=1. Then 0x0003+0xFFFE → out=0x0001.
- reset=1 together with in_valid=1 and operands 5+6 → after the edge out_q=0, out_valid=0, while combinational out=0x000B. Release reset with in_valid=0 → out_valid stays 0 and out_q holds 0.
- Back-to-back in_valid stream (1+2, 3+4, 10+20) → out_q shows 3, 7, 30 on consecutive cycles with out_valid=1. Drop in_valid → out_q holds 30 and out_valid=0.
